// File: rtl/bin_to_7seg_scan.sv
// bin_to_7seg_scan
// Shows a 4-bit binary value (0-15) as two decimal digits on a
// time-multiplexed, common-anode 7-segment display. The input is sampled
// once per scan so a units/tens pair always comes from one sample.
// Each digit stays lit for REFRESH_CYCLES clocks. Outputs are registered.
// Optional build macro: BLANK_LEADING_ZERO_EN blanks a zero tens digit.
module bin_to_7seg_scan #(
    parameter int REFRESH_CYCLES = 50_000
) (
    input  logic       reloj,
    input  logic       reset,
    input  logic [3:0] bin_in,
    output logic [6:0] seg_out,
    output logic [1:0] an_out
);

    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             sel;       // 0 = units digit lit, 1 = tens digit lit
    logic [3:0]       hold;      // value displayed for the whole scan
    logic             terminal;
    logic [3:0]       tens;
    logic [3:0]       units;
    logic [3:0]       digit;
    logic [6:0]       seg_next;

    // Active-low gfedcba patterns for decimal digits; anything else is blank.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Last cycle of the current digit's lit period.
    always_comb begin
        terminal = (cnt == CNT_LAST);
    end

    // Refresh counter, digit select toggle, and once-per-scan capture.
    // The capture happens on the tens->units transition, so the units digit
    // that follows already uses the new value.
    always_ff @(posedge reloj) begin
        if (reset) begin
            cnt  <= '0;
            sel  <= 1'b0;
            hold <= 4'd0;
        end else begin
            if (terminal) begin
                cnt <= '0;
                sel <= ~sel;
                if (sel) begin
                    hold <= bin_in;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Decimal split: the input never exceeds 15, so tens is only 0 or 1.
    always_comb begin
        tens  = 4'd0;
        units = hold;
        if (hold >= 4'd10) begin
            tens  = 4'd1;
            units = hold - 4'd10;
        end
    end

    // Pick the digit for the lit anode and encode it.
    always_comb begin
        digit    = sel ? tens : units;
        seg_next = seg_encode(digit);
`ifdef BLANK_LEADING_ZERO_EN
        if (sel && (tens == 4'd0)) begin
            seg_next = 7'h7F;
        end
`endif
    end

    // Registered display drive, one cycle behind sel/hold.
    always_ff @(posedge reloj) begin
        if (reset) begin
            an_out  <= 2'b11;
            seg_out <= 7'h7F;
        end else begin
            an_out  <= sel ? 2'b01 : 2'b10;
            seg_out <= seg_next;
        end
    end

endmodule

// File: doc/bin_to_7seg_scan.md
# bin_to_7seg_scan

Displays the 4-bit binary value produced by the Gray-to-binary decoder as a two-digit decimal number (00–15) on a time-multiplexed, common-anode 7-segment display. The block sits directly downstream of the decoder. It captures the decoder output once per scan, so a digit pair never shows values from two different samples. It then splits the value into tens and units and alternates the two anodes at a parameterised refresh rate.

## Interface
- `REFRESH_CYCLES`, default 50_000: clock cycles each digit stays lit; legal range ≥ 2.
- `reloj` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `bin_in` in 4: binary value from the Gray-to-binary decoder, unsigned 0–15.
- `seg_out` out 7: segment drive, active-low; bit 0 = a … bit 6 = g.
- `an_out` out 2: anode enables, active-low; bit 0 = units, bit 1 = tens.

## Operation
- **Refresh counter `cnt`**
  - Width is $clog2(REFRESH_CYCLES).
  - Counts 0..REFRESH_CYCLES-1, then wraps to 0.
  - "Terminal" means cnt == REFRESH_CYCLES-1.
- **Digit select `sel`** (0 = units, 1 = tens)
  - Toggles on every terminal cycle.
- **Hold register `hold[3:0]`**
  - Loads `bin_in` only on a terminal cycle with sel == 1, i.e. at the start of each new scan.
  - Otherwise `hold` keeps its value, and `bin_in` changes mid-scan are ignored.
- **Digit split** (combinational from `hold`)
  - hold ≥ 10: tens = 1, units = hold − 10.
  - Otherwise: tens = 0, units = hold.
  - No value is outside 0–15, so no overflow handling is needed.
- **Segment encoding**, active-low gfedcba:
  - 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19
  - 5 = 7'h12, 6 = 7'h02, 7 = 7'h78, 8 = 7'h00, 9 = 7'h10
- **Output registers**
  - Each cycle, `an_out` ← (sel ? 2'b01 : 2'b10).
  - Each cycle, `seg_out` ← encoding of (sel ? tens : units).
  - Exactly one anode is low at any time outside reset.
- **Reset values**
  - cnt = 0, sel = 0, hold = 0.
  - an_out = 2'b11 (all off), seg_out = 7'h7F (all off).
- **Reset mid-scan**
  - Asserting reset on any cycle forces all of the above reset values on the next edge, regardless of cnt, sel or `bin_in`.
  - The next scan begins from units with hold = 0.

## Timing
- Outputs are registered, one cycle behind internal state.
  - `an_out` and `seg_out` change on the edge after `sel` or `hold` changes.
- First cycle after reset deasserts:
  - an_out = 2'b10, seg_out = 7'h40 (units "0" of hold = 0).
- Each digit stays lit for exactly REFRESH_CYCLES cycles.
  - Full scan period = 2 × REFRESH_CYCLES.
- Capture latency:
  - A new `bin_in` is displayed between 1 and 2 × REFRESH_CYCLES + 1 cycles after it becomes stable.
  - The exact delay depends on scan phase.
- Simultaneous events:
  - On the terminal cycle with sel == 1, the hold load and the sel toggle occur on the same edge.
  - The units display that follows uses the new `hold`.
- Reset has priority over every counter, select and load action.

## Configuration
- Macro: `BLANK_LEADING_ZERO_EN`.
- Defined:
  - When sel == 1 and tens == 0, seg_out = 7'h7F (blank).
  - an_out still follows the normal pattern, so the scan timing is unchanged.
  - Values 0–9 show as a single digit.
- Not defined:
  - The tens digit always shows its encoding; 0–9 display as 00–09.

## Test plan
Run all scenarios with REFRESH_CYCLES = 4.
- **Reset**
  - Stimulus: hold reset high for 3 cycles with bin_in = 4'd13.
  - Required: an_out = 2'b11, seg_out = 7'h7F throughout.
  - Required, first cycle after release: an_out = 2'b10, seg_out = 7'h40.
- **Scan order**
  - Stimulus: bin_in = 4'd13 held from reset.
  - Required, second scan: units shows 7'h30 ("3") for 4 cycles, then tens shows 7'h79 ("1") for 4 cycles, repeating.
- **Mid-scan change**
  - Stimulus: bin_in changes 4'd7 → 4'd12 while sel == 0.
  - Required: the current scan finishes with 7/0.
  - Required: the next scan shows units 7'h24, tens 7'h79.
- **Boundaries**
  - bin_in = 4'd9 → units 7'h10, tens 0 (7'h40, or 7'h7F with the macro defined).
  - bin_in = 4'd10 → units 7'h40, tens 7'h79.
  - bin_in = 4'd15 → units 7'h12, tens 7'h79.
- **Reset mid-scan**
  - Stimulus: reset pulsed for 1 cycle at cnt = 2, sel = 1, while showing 15.
  - Required: outputs blank for one cycle.
  - Required: display then restarts at the units digit showing 7'h40.
- **Full sweep**
  - Stimulus: drive bin_in through 0–15, 2 scans each.
  - Required: every displayed digit pair matches its decimal value.
  - Required: exactly one anode is low on every non-reset cycle.
